// File: rtl/imem_dmem_bus_arbiter.sv
// rtl/imem_dmem_bus_arbiter.sv - two-master (IMEM/DMEM) to single memory bus transaction arbiter
//
// Purpose:
//   Merges the instruction-side and data-side memory-bus masters onto one
//   external bus. Whole transactions (single beats or INCR/WRAP line bursts)
//   are arbitrated; the grant is held until the last qualified ACK or until
//   the owner drops its request, followed by one mandatory IDLE cycle.
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, contested grants alternate between the
//                        masters; otherwise DMEM has fixed priority.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   im_* (addr/burst/req/wrb/     IMEM master request side
//         wdata/bstrobe)
//   im_rdata/im_ack/im_stall      IMEM response side (only while IMEM owns)
//   dm_*                          DMEM master, same meaning as im_*
//   ADDR/BURST/REQ/WRB/WDATA/     external bus request side
//   BSTROBE
//   RDATA/ACK/STALL               external bus response side
//   owner                         00 none, 01 IMEM, 10 DMEM (registered)
//   busy                          transaction in progress (registered)

module imem_dmem_bus_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] im_addr,
  input  logic [1:0]  im_burst,
  input  logic        im_req,
  input  logic        im_wrb,
  input  logic [31:0] im_wdata,
  input  logic [3:0]  im_bstrobe,
  output logic [31:0] im_rdata,
  output logic        im_ack,
  output logic        im_stall,
  input  logic [31:0] dm_addr,
  input  logic [1:0]  dm_burst,
  input  logic        dm_req,
  input  logic        dm_wrb,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_bstrobe,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        dm_stall,
  output logic [31:0] ADDR,
  output logic [1:0]  BURST,
  output logic        REQ,
  output logic        WRB,
  output logic [31:0] WDATA,
  output logic [3:0]  BSTROBE,
  input  logic [31:0] RDATA,
  input  logic        ACK,
  input  logic        STALL,
  output logic [1:0]  owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_IM = 2'b01,
    OWN_DM = 2'b10
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_owner;
  logic             r_busy;

  logic             w_grant_dm;
  logic             w_x_req;
  logic [1:0]       w_x_burst;
  logic             w_beat;
  logic             w_line_burst;
  logic             w_last;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = IMEM won the previous grant, 1 = DMEM won it.
  logic r_last_owner;

  // On contention the master that did not win last time is served.
  assign w_grant_dm = dm_req & (~im_req | ~r_last_owner);
`else
  assign w_grant_dm = dm_req;
`endif

  // Request and burst type of whichever master currently owns the bus.
  assign w_x_req   = (r_state == OWN_IM) ? im_req :
                     (r_state == OWN_DM) ? dm_req : 1'b0;
  assign w_x_burst = (r_state == OWN_IM) ? im_burst :
                     (r_state == OWN_DM) ? dm_burst : 2'b00;

  // A beat only counts when the slave acknowledges without stalling.
  assign w_beat       = ACK & ~STALL;
  // 01 INCR and 10 WRAP are line bursts; 00 and reserved 11 are single beats.
  assign w_line_burst = w_x_burst[0] ^ w_x_burst[1];
  assign w_last       = w_beat & (~w_line_burst | (r_cnt == CNT_W'(BURST_LEN - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= 2'b00;
      r_busy  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_owner <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (im_req | dm_req) begin
            r_busy <= 1'b1;
            if (w_grant_dm) begin
              r_state <= OWN_DM;
              r_owner <= 2'b10;
`ifdef ARB_ROUND_ROBIN_EN
              r_last_owner <= 1'b1;
`endif
            end else begin
              r_state <= OWN_IM;
              r_owner <= 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
              r_last_owner <= 1'b0;
`endif
            end
          end
        end
        OWN_IM, OWN_DM: begin
          // Dropping the request aborts; the last beat completes. Either way
          // the next cycle is the mandatory IDLE bubble.
          if (!w_x_req || w_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_owner <= 2'b00;
            r_busy  <= 1'b0;
          end else if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_owner <= 2'b00;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Bus side is a pure mux from the owner; the non-owner is held stalled.
  always_comb begin
    ADDR     = '0;
    BURST    = 2'b00;
    REQ      = 1'b0;
    WRB      = 1'b0;
    WDATA    = '0;
    BSTROBE  = 4'h0;
    im_rdata = '0;
    im_ack   = 1'b0;
    im_stall = 1'b1;
    dm_rdata = '0;
    dm_ack   = 1'b0;
    dm_stall = 1'b1;
    case (r_state)
      OWN_IM: begin
        ADDR     = im_addr;
        BURST    = im_burst;
        REQ      = im_req;
        WRB      = im_wrb;
        WDATA    = im_wdata;
        BSTROBE  = im_bstrobe;
        im_rdata = RDATA;
        // An ACK arriving in the abort cycle is swallowed.
        im_ack   = ACK & im_req;
        im_stall = STALL;
      end
      OWN_DM: begin
        ADDR     = dm_addr;
        BURST    = dm_burst;
        REQ      = dm_req;
        WRB      = dm_wrb;
        WDATA    = dm_wdata;
        BSTROBE  = dm_bstrobe;
        dm_rdata = RDATA;
        dm_ack   = ACK & dm_req;
        dm_stall = STALL;
      end
      default: begin
      end
    endcase
  end

  assign owner = r_owner;
  assign busy  = r_busy;

endmodule

// File: tb/tb_imem_dmem_bus_arbiter.sv
// tb/tb_imem_dmem_bus_arbiter.sv - self-checking bench for imem_dmem_bus_arbiter
//
// Purpose:
//   Drives directed transactions followed by random traffic and compares every
//   DUT output each cycle against a transaction-level model (current owner,
//   beats completed, previous winner).
//
// Build option:
//   ARB_ROUND_ROBIN_EN - model and expected grant order follow the DUT build.

module tb_imem_dmem_bus_arbiter;

  localparam int BURST_LEN = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr, dm_addr, im_wdata, dm_wdata, RDATA;
  logic [1:0]  im_burst, dm_burst;
  logic        im_req, dm_req, im_wrb, dm_wrb, ACK, STALL;
  logic [3:0]  im_bstrobe, dm_bstrobe;
  logic [31:0] im_rdata, dm_rdata, ADDR, WDATA;
  logic        im_ack, im_stall, dm_ack, dm_stall, REQ, WRB, busy;
  logic [1:0]  BURST, owner;
  logic [3:0]  BSTROBE;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: 0 none, 1 IMEM, 2 DMEM.
  int m_owner;
  int m_done;
  int m_last;

  always #5 clk = ~clk;

  imem_dmem_bus_arbiter #(.BURST_LEN(BURST_LEN), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .im_addr(im_addr), .im_burst(im_burst), .im_req(im_req), .im_wrb(im_wrb),
    .im_wdata(im_wdata), .im_bstrobe(im_bstrobe),
    .im_rdata(im_rdata), .im_ack(im_ack), .im_stall(im_stall),
    .dm_addr(dm_addr), .dm_burst(dm_burst), .dm_req(dm_req), .dm_wrb(dm_wrb),
    .dm_wdata(dm_wdata), .dm_bstrobe(dm_bstrobe),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .ADDR(ADDR), .BURST(BURST), .REQ(REQ), .WRB(WRB), .WDATA(WDATA),
    .BSTROBE(BSTROBE), .RDATA(RDATA), .ACK(ACK), .STALL(STALL),
    .owner(owner), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_done  = 0;
    m_last  = 0;
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_update();
    int win;
    int need;
    logic       o_req;
    logic [1:0] o_burst;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner == 0) begin
      if (im_req || dm_req) begin
        if (im_req && dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          win = (m_last == 0) ? 2 : 1;
`else
          win = 2;
`endif
        end else begin
          win = dm_req ? 2 : 1;
        end
        m_owner = win;
        m_done  = 0;
        m_last  = (win == 2) ? 1 : 0;
      end
    end else begin
      o_req   = (m_owner == 1) ? im_req : dm_req;
      o_burst = (m_owner == 1) ? im_burst : dm_burst;
      if (!o_req) begin
        m_owner = 0;
      end else if (ACK && !STALL) begin
        m_done++;
        need = (o_burst == 2'b01 || o_burst == 2'b10) ? BURST_LEN : 1;
        if (m_done >= need) m_owner = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic im_own, dm_own;
    im_own = (m_owner == 1);
    dm_own = (m_owner == 2);
    chk("owner",   32'(owner), 32'(m_owner));
    chk("busy",    32'(busy), 32'(m_owner != 0));
    chk("REQ",     32'(REQ), im_own ? 32'(im_req) : dm_own ? 32'(dm_req) : 32'd0);
    chk("ADDR",    ADDR, im_own ? im_addr : dm_own ? dm_addr : 32'd0);
    chk("BURST",   32'(BURST), im_own ? 32'(im_burst) : dm_own ? 32'(dm_burst) : 32'd0);
    chk("WRB",     32'(WRB), im_own ? 32'(im_wrb) : dm_own ? 32'(dm_wrb) : 32'd0);
    chk("WDATA",   WDATA, im_own ? im_wdata : dm_own ? dm_wdata : 32'd0);
    chk("BSTROBE", 32'(BSTROBE), im_own ? 32'(im_bstrobe) : dm_own ? 32'(dm_bstrobe) : 32'd0);
    chk("im_rdata", im_rdata, im_own ? RDATA : 32'd0);
    chk("im_ack",   32'(im_ack), 32'(im_own && im_req && ACK));
    chk("im_stall", 32'(im_stall), im_own ? 32'(STALL) : 32'd1);
    chk("dm_rdata", dm_rdata, dm_own ? RDATA : 32'd0);
    chk("dm_ack",   32'(dm_ack), 32'(dm_own && dm_req && ACK));
    chk("dm_stall", 32'(dm_stall), dm_own ? 32'(STALL) : 32'd1);
  endtask

  // Inputs are set while clk is low; check, clock, update model, return low.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    int acks;
    int got[3];
    int exp_ord[3];
    rst_n = 1'b0;
    im_addr = '0; im_burst = 2'b00; im_req = 1'b0; im_wrb = 1'b0;
    im_wdata = '0; im_bstrobe = 4'h0;
    dm_addr = '0; dm_burst = 2'b00; dm_req = 1'b0; dm_wrb = 1'b0;
    dm_wdata = '0; dm_bstrobe = 4'h0;
    RDATA = '0; ACK = 1'b0; STALL = 1'b0;
    model_reset();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // IMEM INCR burst, one stalled cycle after beat 3.
    im_req = 1'b1; im_burst = 2'b01; im_addr = 32'h0000_1000;
    step();
    acks = 0;
    for (int i = 0; i < 9; i++) begin
      ACK   = (i != 3);
      STALL = (i == 3);
      RDATA = $urandom;
      #1;
      if (im_ack && !im_stall) acks++;
      step();
    end
    im_req = 1'b0; ACK = 1'b0; STALL = 1'b0;
    chk("incr_ack_count", 32'(acks), 32'd8);
    chk("incr_owner_after", 32'(owner), 32'd0);
    step();

    // DMEM single write.
    dm_req = 1'b1; dm_burst = 2'b00; dm_wrb = 1'b1;
    dm_wdata = 32'hDEAD_BEEF; dm_bstrobe = 4'hF; dm_addr = 32'h0000_2000;
    step();
    #1;
    chk("dm_wr_wdata", WDATA, 32'hDEAD_BEEF);
    chk("dm_wr_wrb", 32'(WRB), 32'd1);
    chk("dm_wr_im_stall", 32'(im_stall), 32'd1);
    ACK = 1'b1;
    step();
    dm_req = 1'b0; dm_wrb = 1'b0; ACK = 1'b0;
    chk("dm_wr_owner_after", 32'(owner), 32'd0);
    step();

    // Asynchronous reset in the middle of an IMEM burst with three beats done.
    im_req = 1'b1; im_burst = 2'b01;
    step();
    ACK = 1'b1;
    for (int i = 0; i < 3; i++) step();
    ACK = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_req", 32'(REQ), 32'd0);
    chk("rst_im_stall", 32'(im_stall), 32'd1);
    chk("rst_cnt", 32'(dut.r_cnt), 32'd0);
    im_req = 1'b0; im_burst = 2'b00;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Simultaneous requests: DMEM first, IMEM after its last ACK plus a bubble.
    im_req = 1'b1; dm_req = 1'b1;
    step();
    chk("sim_first_owner", 32'(owner), 32'd2);
    ACK = 1'b1;
    step();
    dm_req = 1'b0; ACK = 1'b0;
    chk("sim_bubble_owner", 32'(owner), 32'd0);
    step();
    chk("sim_second_owner", 32'(owner), 32'd1);
    ACK = 1'b1;
    step();
    im_req = 1'b0; ACK = 1'b0;
    step();

    // Three contested rounds.
`ifdef ARB_ROUND_ROBIN_EN
    exp_ord[0] = 2; exp_ord[1] = 1; exp_ord[2] = 2;
`else
    exp_ord[0] = 2; exp_ord[1] = 2; exp_ord[2] = 2;
`endif
    for (int r = 0; r < 3; r++) begin
      im_req = 1'b1; dm_req = 1'b1;
      step();
      got[r] = int'(owner);
      ACK = 1'b1;
      step();
      im_req = 1'b0; dm_req = 1'b0; ACK = 1'b0;
      step();
    end
    for (int r = 0; r < 3; r++) chk($sformatf("contest_round%0d", r), 32'(got[r]), 32'(exp_ord[r]));

    // Abort after two of eight beats, stray ACK afterwards, then DMEM request.
    im_req = 1'b1; im_burst = 2'b01;
    step();
    ACK = 1'b1;
    step();
    step();
    im_req = 1'b0; ACK = 1'b0;
    step();
    ACK = 1'b1;
    #1;
    chk("abort_stray_ack", 32'(im_ack), 32'd0);
    chk("abort_owner", 32'(owner), 32'd0);
    step();
    ACK = 1'b0; dm_req = 1'b1; dm_burst = 2'b00;
    step();
    chk("abort_dm_granted", 32'(owner), 32'd2);
    ACK = 1'b1;
    step();
    dm_req = 1'b0; ACK = 1'b0;
    step();

    // Random traffic; a master only changes BURST while it does not own the bus.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) im_req = ~im_req;
      if ($urandom_range(0, 5) == 0) dm_req = ~dm_req;
      if (m_owner != 1) im_burst = 2'($urandom);
      if (m_owner != 2) dm_burst = 2'($urandom);
      im_addr = $urandom; dm_addr = $urandom;
      im_wdata = $urandom; dm_wdata = $urandom;
      im_wrb = 1'($urandom); dm_wrb = 1'($urandom);
      im_bstrobe = 4'($urandom); dm_bstrobe = 4'($urandom);
      RDATA = $urandom;
      ACK   = ($urandom_range(0, 2) != 0);
      STALL = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
